uart_rx_edge_bit_sampler: RTL
=============================

// Module: uart_rx_edge_bit_sampler
// PURPOSE
//   Oversampling timebase and bit sampler for the UART receiver, directly upstream of the RX control FSM.
//   Synchronises RX_IN and produces edge_cnt/bit_cnt for the FSM.
//   Produces sampled_bit, a per-bit sample, for the deserializer and the parity, start and stop checkers.
//   Active only while the FSM drives enable; idle otherwise.
// PARAMETERS
//   PRESCALE_W   6   width of prescale and edge_cnt
//   BIT_CNT_W    4   width of bit_cnt
//   SYNC_STAGES  2   flops in RX_IN synchroniser (>=2)
// PORTS
//   clk          in   1             receiver oversampling clock
//   rst          in   1             synchronous, active-high reset
//   RX_IN        in   1             raw serial line, idle high
//   enable       in   1             FSM: run counters (frame in progress)
//   dat_samp_en  in   1             FSM: allow sampling of RX line
//   prescale     in   PRESCALE_W    oversampling ratio (legal: even, >=4; nominal 8/16/32)
//   rx_sync      out  1             synchronised RX_IN (FSM start detection uses this)
//   edge_cnt     out  PRESCALE_W    oversample index within current bit, 0..pre_q-1
//   bit_cnt      out  BIT_CNT_W     bit index within frame (0 = start bit)
//   bit_done     out  1             1-cycle pulse on last edge of a bit (edge_cnt==pre_q-1)
//   sampled_bit  out  1             decided value of current bit
//   sample_valid out  1             1-cycle pulse when sampled_bit updates
//   cfg_err      out  1             1-cycle pulse: illegal prescale at latch time
// BEHAVIOUR
//   Reset: edge_cnt=0, bit_cnt=0, bit_done=0, sampled_bit=1, sample_valid=0, cfg_err=0.
//   Reset also sets rx_sync and all sync flops to 1, and pre_q to 8.
//   Synchroniser: rx_sync = RX_IN delayed SYNC_STAGES clocks; all sampling uses rx_sync.
//   Prescale latch (pre_q):
//     - Latched on the cycle enable rises 0->1. Ignored mid-frame.
//     - Latch cycle counts as edge 0 and uses the live legal value.
//     - Illegal value (odd or <4): latch 8 and pulse cfg_err that cycle.
//   mid = pre_q>>1.
//   Counters, when enable=1:
//     - edge_cnt increments each clk.
//     - At edge_cnt==pre_q-1: edge_cnt->0, bit_cnt+1 (saturates at all-ones), bit_done=1.
//   enable=0: edge_cnt and bit_cnt clear to 0 next clk; bit_done=0; sampled_bit holds.
//   enable falling on the same clk as a wrap: the clear wins.
//   Sampling: only when enable & dat_samp_en. Samples are taken at edge_cnt = mid-2, mid-1, mid.
//   Decision: registered at edge_cnt==mid, so sampled_bit is updated while edge_cnt==mid+1.
//     - sample_valid pulses for exactly that cycle, once per bit.
//     - sampled_bit is stable from mid+1 to end of bit.
//   If dat_samp_en drops inside the sample window, no update and no sample_valid for that bit.
//   Reset mid-frame: all state returns to reset values next clk regardless of enable.
// CONFIGURATION
//   UART_RX_MAJORITY_VOTE_EN defined:
//     - sampled_bit = majority of the three samples (mid-2, mid-1, mid).
//     - Single-sample glitches are rejected.
//   Not defined:
//     - sampled_bit = single sample at edge_cnt==mid.
//     - Samples at mid-2/mid-1 are not stored.
//   Output timing (sample_valid at mid+1) is identical in both builds.
// TESTING
//   T1 reset:
//     - Assert rst 2 clks mid-frame (edge_cnt=5, bit_cnt=3).
//     - Next clk all outputs are at reset values; rx_sync=1.
//   T2 counting:
//     - prescale=8, enable=1 for 80 clks.
//     - edge_cnt cycles 0..7.
//     - bit_done every 8th clk; bit_cnt reaches 10 after 80 clks.
//     - Drop enable: both counters are 0 next clk.
//   T3 frame 0xA5:
//     - prescale=16, 8N1 line driven LSB first.
//     - 10 sample_valid pulses, each at edge_cnt==9.
//     - sampled_bit sequence 0,1,0,1,0,0,1,0,1,1.
//   T4 glitch, edge_cnt 7 of a '1' bit:
//     - prescale=16, 1-clk low pulse on rx_sync.
//     - With macro: sampled_bit=1.
//     - Without macro: glitch at edge 8 gives sampled_bit=0; glitch at edge 7 gives 1.
//   T5 prescale handling:
//     - prescale changed 16->8 mid-frame: period stays 16 until enable re-rises.
//     - prescale=7 at latch: cfg_err pulse, period 8.
//   T6 dat_samp_en:
//     - Deassert dat_samp_en during edges 6..8 of bit 2 (prescale=16).
//     - No sample_valid for bit 2; sampled_bit holds bit 1's value.

Source files
------------

// File: rtl/uart_rx_edge_bit_sampler.sv
// UART RX oversampling timebase and bit sampler: synchronises RX_IN, runs edge/bit counters, decides each bit.
// Optional build macro UART_RX_MAJORITY_VOTE_EN selects a 3-sample majority vote instead of a single mid-bit sample.
module uart_rx_edge_bit_sampler #(
  parameter int PRESCALE_W  = 6,
  parameter int BIT_CNT_W   = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  RX_IN,
  input  logic                  enable,
  input  logic                  dat_samp_en,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  rx_sync,
  output logic [PRESCALE_W-1:0] edge_cnt,
  output logic [BIT_CNT_W-1:0]  bit_cnt,
  output logic                  bit_done,
  output logic                  sampled_bit,
  output logic                  sample_valid,
  output logic                  cfg_err
);

  logic [SYNC_STAGES-1:0] sync_p0;
  logic                   en_p1;
  logic                   win_ok_p1;
  logic [PRESCALE_W-1:0]  pre_q;
  logic [PRESCALE_W-1:0]  pre_eff;
  logic [PRESCALE_W-1:0]  mid;
  logic [PRESCALE_W-1:0]  mid_m1;
  logic [PRESCALE_W-1:0]  mid_m2;
  logic [PRESCALE_W-1:0]  last_edge;
  logic                   en_rise;
  logic                   pre_legal;
  logic                   wrap;
  logic                   samp_en;
  logic                   decide;
  logic                   decision;

  function automatic logic [BIT_CNT_W-1:0] sat_inc(input logic [BIT_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

`ifdef UART_RX_MAJORITY_VOTE_EN
  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction
`endif

  // On the latch cycle the live prescale already drives the counters and sample points.
  assign pre_legal = ~prescale[0] && (prescale >= PRESCALE_W'(4));
  assign en_rise   = enable & ~en_p1;
  assign pre_eff   = en_rise ? (pre_legal ? prescale : PRESCALE_W'(8)) : pre_q;
  assign mid       = pre_eff >> 1;
  assign mid_m1    = mid - PRESCALE_W'(1);
  assign mid_m2    = mid - PRESCALE_W'(2);
  assign last_edge = pre_eff - PRESCALE_W'(1);
  assign wrap      = enable && (edge_cnt == last_edge);
  assign samp_en   = enable & dat_samp_en;
  assign decide    = samp_en && win_ok_p1 && (edge_cnt == mid);

  assign rx_sync  = sync_p0[SYNC_STAGES-1];
  assign bit_done = ~rst & wrap;
  assign cfg_err  = ~rst & en_rise & ~pre_legal;

`ifdef UART_RX_MAJORITY_VOTE_EN
  logic samp_a_p1;
  logic samp_b_p1;

  // Early samples of the window; only meaningful when the window completes.
  always_ff @(posedge clk) begin
    if (samp_en && (edge_cnt == mid_m2)) samp_a_p1 <= rx_sync;
    if (samp_en && (edge_cnt == mid_m1)) samp_b_p1 <= rx_sync;
  end

  assign decision = majority3(samp_a_p1, samp_b_p1, rx_sync);
`else
  assign decision = rx_sync;
`endif

  // Synchroniser, prescale latch, counters, sample window and decision register
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0      <= '1;
      en_p1        <= 1'b0;
      pre_q        <= PRESCALE_W'(8);
      edge_cnt     <= '0;
      bit_cnt      <= '0;
      win_ok_p1    <= 1'b0;
      sample_valid <= 1'b0;
      sampled_bit  <= 1'b1;
    end else begin
      sync_p0 <= {sync_p0[SYNC_STAGES-2:0], RX_IN};
      en_p1   <= enable;
      if (en_rise) pre_q <= pre_eff;

      if (!enable) begin
        edge_cnt <= '0;
        bit_cnt  <= '0;
      end else if (wrap) begin
        edge_cnt <= '0;
        bit_cnt  <= sat_inc(bit_cnt);
      end else begin
        edge_cnt <= edge_cnt + 1'b1;
      end

      // Window is valid only if sampling stays enabled across all three points.
      if (edge_cnt == mid_m2)      win_ok_p1 <= samp_en;
      else if (edge_cnt == mid_m1) win_ok_p1 <= win_ok_p1 & samp_en;

      sample_valid <= decide;
      if (decide) sampled_bit <= decision;
    end
  end

endmodule
